// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and constants for the FIFO stream reader and its skid buffer.
package fifo_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } rd_state_e;

    localparam int BUF_DEPTH = 2;

    // True when a new pop can be issued without overrunning the buffer.
    // A word leaving downstream this cycle frees a slot.
    function automatic logic has_space(input logic [1:0] occ,
                                       input logic       inflight,
                                       input logic       xfer);
        return ({1'b0, occ} + {2'b00, inflight}) < (3'(BUF_DEPTH) + {2'b00, xfer});
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// Bundles the FIFO read port and the outgoing valid/ready stream of fifo_stream_reader.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_ren;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_empty;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;

    modport master (
        output fifo_ren, m_valid, m_data,
        input  fifo_rdata, fifo_empty, m_ready
    );

    modport slave (
        input  fifo_ren, m_valid, m_data,
        output fifo_rdata, fifo_empty, m_ready
    );
endinterface

// File: rtl/stream_skid_buf.sv
// stream_skid_buf: 2-entry FIFO-ordered holding buffer with push/pop/clear and a registered head.
module stream_skid_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    input  logic                  clear_i,
    output logic [1:0]            occupancy_o,
    output logic [DATA_WIDTH-1:0] head_o
);
    logic [DATA_WIDTH-1:0] head_q, head_d;
    logic [DATA_WIDTH-1:0] tail_q, tail_d;
    logic [1:0]            occ_q, occ_d;

    // Clear wins over everything; push into a full buffer is never requested by the caller.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (clear_i) begin
            occ_d = 2'd0;
        end else begin
            case ({push_i, pop_i})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_d = push_data_i;
                    end else begin
                        tail_d = push_data_i;
                    end
                    if (occ_q < 2'(BUF_DEPTH)) begin
                        occ_d = occ_q + 2'd1;
                    end
                end
                2'b01: begin
                    if (occ_q != 2'd0) begin
                        head_d = tail_q;
                        occ_d  = occ_q - 2'd1;
                    end
                end
                2'b11: begin
                    if (occ_q == 2'd2) begin
                        head_d = tail_q;
                        tail_d = push_data_i;
                    end else begin
                        head_d = push_data_i;
                        occ_d  = 2'd1;
                    end
                end
                default: begin
                    occ_d = occ_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign occupancy_o = occ_q;
    assign head_o      = head_q;
endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a FIFO read port into a valid/ready stream through a 2-entry skid buffer.
// Define FIFO_STREAM_READER_STATS_EN to add the saturating stall_count output.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int    DATA_WIDTH        = 8,
    parameter string READ_FALL_THROUGH = "TRUE",
    parameter int    CNT_WIDTH         = 16
) (
    input  logic                 fifo_rclk,
    input  logic                 fifo_rrst,
    input  logic                 en,
    input  logic                 flush,
    fifo_stream_reader_if.master rd_if,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] word_count
`ifdef FIFO_STREAM_READER_STATS_EN
    ,
    output logic [CNT_WIDTH-1:0] stall_count
`endif
);
    localparam bit FALL_THROUGH = (READ_FALL_THROUGH == "TRUE");

    rd_state_e             state_q, state_d;
    logic                  inflight_q, inflight_d;
    logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;
    logic [1:0]            occupancy;
    logic [DATA_WIDTH-1:0] head;
    logic                  valid_out;
    logic                  xfer;
    logic                  space_ok;
    logic                  pop_req;
    logic                  push;
    logic                  clear_buf;
    logic                  busy_int;

    assign valid_out = (occupancy != 2'd0) && (state_q != FLUSH);
    assign xfer      = valid_out && rd_if.m_ready;
    assign space_ok  = has_space(occupancy, inflight_q, xfer);

    always_ff @(posedge fifo_rclk) begin
        if (fifo_rrst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush && state_q != FLUSH) begin
            state_d = FLUSH;
        end else begin
            case (state_q)
                IDLE:    if (en) state_d = RUN;
                RUN:     if (!en) state_d = IDLE;
                FLUSH:   if (rd_if.fifo_empty && !inflight_q) state_d = en ? RUN : IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // In FLUSH every popped or landing word is thrown away, so push is gated off there.
    always_comb begin
        pop_req   = 1'b0;
        busy_int  = (state_q == FLUSH);
        clear_buf = flush || (state_q == FLUSH);
        case (state_q)
            RUN:     pop_req = en && space_ok && !rd_if.fifo_empty;
            FLUSH:   pop_req = !rd_if.fifo_empty;
            default: pop_req = 1'b0;
        endcase
        if (FALL_THROUGH) begin
            push = pop_req && (state_q != FLUSH);
        end else begin
            push = inflight_q && (state_q != FLUSH);
        end
    end

    assign inflight_d   = FALL_THROUGH ? 1'b0 : pop_req;
    assign word_count_d = word_count_q + CNT_WIDTH'(xfer);

    always_ff @(posedge fifo_rclk) begin
        if (fifo_rrst) begin
            inflight_q   <= 1'b0;
            word_count_q <= '0;
        end else begin
            inflight_q   <= inflight_d;
            word_count_q <= word_count_d;
        end
    end

    stream_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk_i       (fifo_rclk),
        .rst_i       (fifo_rrst),
        .push_i      (push),
        .push_data_i (rd_if.fifo_rdata),
        .pop_i       (xfer),
        .clear_i     (clear_buf),
        .occupancy_o (occupancy),
        .head_o      (head)
    );

`ifdef FIFO_STREAM_READER_STATS_EN
    logic [CNT_WIDTH-1:0] stall_count_q, stall_count_d;

    // Saturates instead of wrapping so a long stall never reads as a short one.
    assign stall_count_d = (valid_out && !rd_if.m_ready && !(&stall_count_q))
                         ? stall_count_q + 1'b1 : stall_count_q;

    always_ff @(posedge fifo_rclk) begin
        if (fifo_rrst) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`endif

    assign rd_if.fifo_ren = pop_req;
    assign rd_if.m_valid  = valid_out;
    assign rd_if.m_data   = head;
    assign busy           = busy_int;
    assign word_count     = word_count_q;
endmodule
